// File: rtl/and_reduce_checker.sv
// ---------------------------------------------------------------------------
// and_reduce_checker
//
// Response checker for a cascaded N-input AND block. It receives the same
// input vector x that drives the DUT, plus the DUT output y. It computes the
// expected reduction-AND, aligns that value to the DUT latency, compares one
// sample per cycle for a programmed number of samples, and reports error
// statistics.
//
// Optional feature (compile-time macro):
//   AND_CHK_STOP_ON_ERR_EN - when defined, the first mismatch ends the run:
//                            CHECK moves to DONE in the following cycle.
//                            When undefined, every run completes all
//                            num_samples comparisons.
// ---------------------------------------------------------------------------
module and_reduce_checker #(
    parameter int LENGTH  = 10,
    parameter int LATENCY = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic [LENGTH-1:0] x,
    input  logic              y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  ones_cnt,
    output logic [LENGTH-1:0] first_err_x
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // The FILL counter only has to reach LATENCY-1; keep it at least 1 bit
    // wide so the declaration stays legal when the line is bypassed.
    localparam int FILL_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    // -----------------------------------------------------------------------
    // Expected-value alignment
    // -----------------------------------------------------------------------
    logic              exp_aligned;
    logic [LENGTH-1:0] x_aligned;

    generate
        if (LATENCY == 0) begin : g_bypass
            // Combinational DUT: compare against the current vector directly.
            assign exp_aligned = &x;
            assign x_aligned   = x;
        end else begin : g_line
            logic [LATENCY-1:0] exp_pipe_q;
            logic [LATENCY-1:0] exp_pipe_d;
            logic [LENGTH-1:0]  x_pipe_q [LATENCY];
            logic [LENGTH-1:0]  x_pipe_d [LATENCY];

            // Next value of the delay line: stage 0 takes the fresh vector,
            // every later stage takes its predecessor.
            always_comb begin
                exp_pipe_d    = '0;
                exp_pipe_d[0] = &x;
                x_pipe_d[0]   = x;
                for (int i = 1; i < LATENCY; i++) begin
                    exp_pipe_d[i] = exp_pipe_q[i-1];
                    x_pipe_d[i]   = x_pipe_q[i-1];
                end
            end

            // Delay line shifts every cycle regardless of the checker state.
            // NOTE: the delay line is a small register array, not a RAM, so it
            // is reset explicitly; a true memory macro could not be cleared
            // this way and would need an initialisation sequence instead.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    exp_pipe_q <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        x_pipe_q[i] <= '0;
                    end
                end else begin
                    exp_pipe_q <= exp_pipe_d;
                    for (int i = 0; i < LATENCY; i++) begin
                        x_pipe_q[i] <= x_pipe_d[i];
                    end
                end
            end

            assign exp_aligned = exp_pipe_q[LATENCY-1];
            assign x_aligned   = x_pipe_q[LATENCY-1];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control and statistics
    // -----------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  num_q,      num_d;
    logic [CNT_W-1:0]  samp_q,     samp_d;
    logic [FILL_W-1:0] fill_q,     fill_d;
    logic [CNT_W-1:0]  err_q,      err_d;
    logic [CNT_W-1:0]  ones_q,     ones_d;
    logic [LENGTH-1:0] first_q,    first_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              pass_q,     pass_d;
    logic              mismatch;

    // Case-inequality so that an X or Z on y is scored as a mismatch in
    // simulation; in hardware this is an ordinary inequality.
    assign mismatch = (y !== exp_aligned);

    // Next-state, counter and registered-output computation.
    // NOTE: every signal gets a default at the top of this block so that no
    // path through the case statement leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        samp_d  = samp_q;
        fill_d  = fill_q;
        err_d   = err_q;
        ones_d  = ones_q;
        first_d = first_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A restart from DONE behaves exactly like a start from IDLE.
                if (start) begin
                    num_d   = num_samples;
                    samp_d  = '0;
                    fill_d  = '0;
                    err_d   = '0;
                    ones_d  = '0;
                    first_d = '0;
                    if (num_samples == '0) begin
                        state_d = S_DONE;
                    end else if (LATENCY > 0) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end

            S_FILL: begin
                // Let the delay line fill with vectors from this run.
                if (fill_q == FILL_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end

            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != CNT_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (err_q == '0) begin
                        first_d = x_aligned;
                    end
                end
                if (exp_aligned && (ones_q != CNT_MAX)) begin
                    ones_d = ones_q + 1'b1;
                end
                samp_d = samp_q + 1'b1;
                if (samp_d == num_q) begin
                    state_d = S_DONE;
                end
`ifdef AND_CHK_STOP_ON_ERR_EN
                if (mismatch) begin
                    state_d = S_DONE;
                end
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are derived from the next state so they are registered
        // alongside it and change on the same edge.
        busy_d = (state_d == S_FILL) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (err_d == '0);
    end

    // All control state and results; an asynchronous reset aborts any run.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            samp_q  <= '0;
            fill_q  <= '0;
            err_q   <= '0;
            ones_q  <= '0;
            first_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            samp_q  <= samp_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
            ones_q  <= ones_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_cnt     = err_q;
    assign ones_cnt    = ones_q;
    assign first_err_x = first_q;

endmodule

// File: tb/tb_and_reduce_checker.sv
// ---------------------------------------------------------------------------
// tb_and_reduce_checker
//
// Directed bench for and_reduce_checker. Two checkers share the stimulus:
// dut0 (LATENCY=0) sees a selectable y (correct, stuck-0, stuck-1 or a
// 2-cycle-delayed correct response); dut2 (LATENCY=2) always sees the
// 2-cycle-delayed correct response. x counts up by one after every edge.
// Honors AND_CHK_STOP_ON_ERR_EN for the expected values.
// ---------------------------------------------------------------------------
module tb_and_reduce_checker;

    localparam int LENGTH = 10;
    localparam int CNT_W  = 16;

    localparam int M_GOOD = 0;
    localparam int M_ZERO = 1;
    localparam int M_ONE  = 2;
    localparam int M_DEL2 = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_samples = '0;
    logic [LENGTH-1:0] x = '0;
    logic              y0 = 1'b0;
    logic              y2 = 1'b0;

    logic              busy0, done0, pass0;
    logic [CNT_W-1:0]  err0, ones0;
    logic [LENGTH-1:0] first0;
    logic              busy2, done2, pass2;
    logic [CNT_W-1:0]  err2, ones2;
    logic [LENGTH-1:0] first2;

    int n_checks = 0;
    int n_fail   = 0;
    int ymode    = M_GOOD;
    logic q1 = 1'b0;
    logic q2 = 1'b0;

    and_reduce_checker #(.LENGTH(LENGTH), .LATENCY(0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .x(x), .y(y0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .ones_cnt(ones0), .first_err_x(first0)
    );

    and_reduce_checker #(.LENGTH(LENGTH), .LATENCY(2), .CNT_W(CNT_W)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .x(x), .y(y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .ones_cnt(ones2), .first_err_x(first2)
    );

    always #5 clk = ~clk;

    task automatic update_y();
        case (ymode)
            M_GOOD:  y0 = &x;
            M_ZERO:  y0 = 1'b0;
            M_ONE:   y0 = 1'b1;
            default: y0 = q2;
        endcase
        y2 = q2;
    endtask

    // One clock: wait for the edge, then advance the 2-flop DUT model and x.
    task automatic step();
        @(posedge clk);
        #1;
        q2 = q1;
        q1 = &x;
        x  = x + 1'b1;
        update_y();
    endtask

    // Launch a run so that the first checked vector is x=1000, then wait
    // (bounded) for both checkers to finish. c0/c2 = cycles after the start
    // edge at which done rose, -1 if the bound expired.
    task automatic run(input int n, input int mode, output int c0, output int c2,
                       output logic busy_after, output logic [CNT_W-1:0] err_after);
        ymode = mode;
        @(posedge clk);
        #1;
        x = 10'd998;
        update_y();
        step();
        start = 1'b1;
        num_samples = CNT_W'(n);
        step();
        start = 1'b0;
        busy_after = busy0;
        err_after  = err0;
        c0 = done0 ? 0 : -1;
        c2 = done2 ? 0 : -1;
        for (int i = 1; i <= 200 && (c0 < 0 || c2 < 0); i++) begin
            step();
            if (c0 < 0 && done0) c0 = i;
            if (c2 < 0 && done2) c2 = i;
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({busy0, done0, pass0, busy2, done2, pass2} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000", {busy0, done0, pass0, busy2, done2, pass2});
        end
        n_checks++;
        if ({err0, ones0, first0, err2, ones2, first2} !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: got err0=%0d ones0=%0d first0=%0d err2=%0d ones2=%0d first2=%0d expected all 0",
                     err0, ones0, first0, err2, ones2, first2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_good_run(input string tag);
        int c0, c2;
        logic b;
        logic [CNT_W-1:0] e;
        run(30, M_GOOD, c0, c2, b, e);
        n_checks++;
        if (c0 !== 30) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected 30", tag, c0); end
        n_checks++;
        if ({pass0, err0, ones0} !== {1'b1, 16'd0, 16'd1}) begin
            n_fail++;
            $display("FAIL %s_stats: got pass=%0d err=%0d ones=%0d expected pass=1 err=0 ones=1", tag, pass0, err0, ones0);
        end
        n_checks++;
        if (first0 !== 10'd0) begin n_fail++; $display("FAIL %s_first_err_x: got %0d expected 0", tag, first0); end
    endtask

    task automatic test_stuck_zero();
        int c0, c2, exp_c;
        logic b;
        logic [CNT_W-1:0] e;
`ifdef AND_CHK_STOP_ON_ERR_EN
        exp_c = 24;
`else
        exp_c = 30;
`endif
        run(30, M_ZERO, c0, c2, b, e);
        n_checks++;
        if (c0 !== exp_c) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected %0d", c0, exp_c); end
        n_checks++;
        if ({pass0, err0, ones0} !== {1'b0, 16'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL zero_stats: got pass=%0d err=%0d ones=%0d expected pass=0 err=1 ones=1", pass0, err0, ones0);
        end
        n_checks++;
        if (first0 !== 10'h3FF) begin n_fail++; $display("FAIL zero_first_err_x: got %h expected 3ff", first0); end
    endtask

    task automatic test_stuck_one();
        int c0, c2, exp_c;
        logic b;
        logic [CNT_W-1:0] e, exp_err, exp_ones;
`ifdef AND_CHK_STOP_ON_ERR_EN
        exp_c = 1;  exp_err = 16'd1;  exp_ones = 16'd0;
`else
        exp_c = 30; exp_err = 16'd29; exp_ones = 16'd1;
`endif
        run(30, M_ONE, c0, c2, b, e);
        n_checks++;
        if (c0 !== exp_c) begin n_fail++; $display("FAIL one_done_cycle: got %0d expected %0d", c0, exp_c); end
        n_checks++;
        if ({pass0, err0, ones0} !== {1'b0, exp_err, exp_ones}) begin
            n_fail++;
            $display("FAIL one_stats: got pass=%0d err=%0d ones=%0d expected pass=0 err=%0d ones=%0d",
                     pass0, err0, ones0, exp_err, exp_ones);
        end
        n_checks++;
        if (first0 !== 10'd1000) begin n_fail++; $display("FAIL one_first_err_x: got %0d expected 1000", first0); end
    endtask

    task automatic test_zero_samples_restart();
        int c0, c2;
        logic b;
        logic [CNT_W-1:0] e;
        // Entered from DONE with err0 nonzero from the previous run.
        run(0, M_GOOD, c0, c2, b, e);
        n_checks++;
        if ({c0, c2} !== {32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL zero_n_done_cycle: got %0d/%0d expected 0/0", c0, c2);
        end
        n_checks++;
        if ({done0, pass0, busy0, err0, ones0, first0} !== {1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL zero_n_results: got done=%0d pass=%0d busy=%0d err=%0d ones=%0d first=%0d expected 1 1 0 0 0 0",
                     done0, pass0, busy0, err0, ones0, first0);
        end
        run(5, M_GOOD, c0, c2, b, e);
        n_checks++;
        if ({b, e} !== {1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL restart_start: got busy=%0d err=%0d expected busy=1 err=0", b, e);
        end
        n_checks++;
        if (c0 !== 5) begin n_fail++; $display("FAIL restart_done_cycle: got %0d expected 5", c0); end
        n_checks++;
        if ({pass0, err0, ones0} !== {1'b1, 16'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL restart_stats: got pass=%0d err=%0d ones=%0d expected pass=1 err=0 ones=0", pass0, err0, ones0);
        end
    endtask

    task automatic test_latency();
        int c0, c2, exp_c;
        logic b;
        logic [CNT_W-1:0] e, exp_err;
`ifdef AND_CHK_STOP_ON_ERR_EN
        exp_c = 24; exp_err = 16'd1;
`else
        exp_c = 30; exp_err = 16'd2;
`endif
        run(30, M_DEL2, c0, c2, b, e);
        n_checks++;
        if (c2 !== 32) begin n_fail++; $display("FAIL lat2_done_cycle: got %0d expected 32", c2); end
        n_checks++;
        if ({busy2, pass2, err2, ones2} !== {1'b0, 1'b1, 16'd0, 16'd1}) begin
            n_fail++;
            $display("FAIL lat2_stats: got busy=%0d pass=%0d err=%0d ones=%0d expected 0 1 0 1", busy2, pass2, err2, ones2);
        end
        n_checks++;
        if (c0 !== exp_c) begin n_fail++; $display("FAIL lat0_delayed_done_cycle: got %0d expected %0d", c0, exp_c); end
        n_checks++;
        if ({pass0, err0, ones0, first0} !== {1'b0, exp_err, 16'd1, 10'h3FF}) begin
            n_fail++;
            $display("FAIL lat0_delayed_stats: got pass=%0d err=%0d ones=%0d first=%h expected pass=0 err=%0d ones=1 first=3ff",
                     pass0, err0, ones0, first0, exp_err);
        end
    endtask

    task automatic test_mid_run_reset();
        ymode = M_ONE;
        @(posedge clk);
        #1;
        x = 10'd998;
        update_y();
        step();
        start = 1'b1;
        num_samples = 16'd30;
        step();
        start = 1'b0;
        repeat (10) step();
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy0, done0, pass0, err0, ones0, first0, busy2, done2, pass2, err2, ones2, first2} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy0=%0d done0=%0d err0=%0d ones0=%0d first0=%0d busy2=%0d err2=%0d expected all 0",
                     busy0, done0, err0, ones0, first0, busy2, err2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_good_run("after_reset");
    endtask

    initial begin
        update_y();
        test_reset();
        test_good_run("good");
        test_stuck_zero();
        test_stuck_one();
        test_zero_samples_restart();
        test_latency();
        test_mid_run_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
